// File: rtl/pf_iod_rx_lane_aligner.sv
// RX word aligner for the DDR3 PHY input IOD: trains against TRAIN_PATTERN using bit-slip.
// Optional delay-line tap sweep on slip exhaustion is enabled by `define PF_IOD_RX_DLY_SWEEP_EN.
module pf_iod_rx_lane_aligner #(
  parameter logic [3:0] TRAIN_PATTERN = 4'b1100,
  parameter int         SLIP_WAIT     = 4,
  parameter int         LOCK_COUNT    = 16,
  parameter int         MAX_TAPS      = 64
) (
  input  logic       FAB_CLK,
  input  logic       RX_SYNC_RST,
  input  logic       TRAIN_START,
  input  logic [3:0] RX_DATA_0,
  output logic       RX_BIT_SLIP,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic [3:0] RX_WORD,
  output logic       RX_VALID,
  output logic       TRAIN_FAIL,
  output logic [1:0] SLIP_CNT
);

  localparam logic [3:0] WAIT_INIT   = 4'(SLIP_WAIT);
  localparam logic [7:0] LOCK_TARGET = 8'(LOCK_COUNT);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_CHECK, ST_SLIP, ST_STEP, ST_LOCKED, ST_FAIL
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] waitCnt_q, waitCnt_d;
  logic [1:0] slipCnt_q, slipCnt_d;
  logic [7:0] matchCnt_q, matchCnt_d;
  logic [3:0] rxWord_q;
  logic       slipPulse_q, slipPulse_d;
  logic       valid_q, valid_d;
  logic       fail_q, fail_d;
  state_e     exhaustState;

`ifdef PF_IOD_RX_DLY_SWEEP_EN
  localparam int              TAP_W    = $clog2(MAX_TAPS);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(MAX_TAPS - 1);

  logic [TAP_W-1:0] tapCnt_q, tapCnt_d;
  logic             move_q, move_d;
  logic             load_q, load_d;

  // Once all four slip positions fail, try the next delay tap unless the line is at its end.
  assign exhaustState = ((tapCnt_q < TAP_LAST) && !DELAY_LINE_OUT_OF_RANGE_0) ? ST_STEP : ST_FAIL;
`else
  logic unused_cfg;

  assign exhaustState = ST_FAIL;
  assign unused_cfg   = ^{DELAY_LINE_OUT_OF_RANGE_0, MAX_TAPS[0]};
`endif

  always_ff @(posedge FAB_CLK) begin
    if (RX_SYNC_RST) begin
      state_q     <= ST_IDLE;
      waitCnt_q   <= '0;
      slipCnt_q   <= '0;
      matchCnt_q  <= '0;
      rxWord_q    <= '0;
      slipPulse_q <= 1'b0;
      valid_q     <= 1'b0;
      fail_q      <= 1'b0;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
      tapCnt_q    <= '0;
      move_q      <= 1'b0;
      load_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      waitCnt_q   <= waitCnt_d;
      slipCnt_q   <= slipCnt_d;
      matchCnt_q  <= matchCnt_d;
      rxWord_q    <= RX_DATA_0;
      slipPulse_q <= slipPulse_d;
      valid_q     <= valid_d;
      fail_q      <= fail_d;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
      tapCnt_q    <= tapCnt_d;
      move_q      <= move_d;
      load_q      <= load_d;
`endif
    end
  end

  // TRAIN_START wins over every other transition, from any state.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    slipCnt_d  = slipCnt_q;
    matchCnt_d = matchCnt_q;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
    tapCnt_d   = tapCnt_q;
`endif
    if (TRAIN_START) begin
      state_d    = ST_WAIT;
      waitCnt_d  = WAIT_INIT;
      slipCnt_d  = '0;
      matchCnt_d = '0;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
      tapCnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_WAIT: begin
          waitCnt_d = (waitCnt_q == 4'd0) ? 4'd0 : waitCnt_q - 4'd1;
          if (waitCnt_q <= 4'd1) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (RX_DATA_0 == TRAIN_PATTERN) begin
            matchCnt_d = (matchCnt_q == LOCK_TARGET) ? matchCnt_q : matchCnt_q + 8'd1;
            if (matchCnt_d == LOCK_TARGET) state_d = ST_LOCKED;
          end else begin
            matchCnt_d = '0;
            state_d    = (slipCnt_q != 2'd3) ? ST_SLIP : exhaustState;
          end
        end
        ST_SLIP: begin
          slipCnt_d = slipCnt_q + 2'd1;
          waitCnt_d = WAIT_INIT;
          state_d   = ST_WAIT;
        end
`ifdef PF_IOD_RX_DLY_SWEEP_EN
        ST_STEP: begin
          tapCnt_d  = tapCnt_q + 1'b1;
          slipCnt_d = '0;
          waitCnt_d = WAIT_INIT;
          state_d   = ST_WAIT;
        end
`else
        ST_STEP:   state_d = ST_FAIL;
`endif
        ST_LOCKED: ;
        ST_FAIL:   ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so every pulse leaves a flop.
  always_comb begin
    slipPulse_d = (state_d == ST_SLIP);
    valid_d     = (state_d == ST_LOCKED);
    fail_d      = (state_d == ST_FAIL);
`ifdef PF_IOD_RX_DLY_SWEEP_EN
    move_d      = (state_d == ST_STEP);
    load_d      = TRAIN_START;
`endif
  end

  assign RX_BIT_SLIP = slipPulse_q;
  assign RX_WORD     = rxWord_q;
  assign RX_VALID    = valid_q;
  assign TRAIN_FAIL  = fail_q;
  assign SLIP_CNT    = slipCnt_q;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
  assign DELAY_LINE_MOVE_0      = move_q;
  assign DELAY_LINE_DIRECTION_0 = move_q;
  assign DELAY_LINE_LOAD_0      = load_q;
`else
  assign DELAY_LINE_MOVE_0      = 1'b0;
  assign DELAY_LINE_DIRECTION_0 = 1'b0;
  assign DELAY_LINE_LOAD_0      = 1'b0;
`endif

endmodule

// File: tb/tb_pf_iod_rx_lane_aligner.sv
// Self-checking bench for pf_iod_rx_lane_aligner: models the IOD rotating its word per slip
// and predicts slip/step/lock/fail cycles from the training rules.
module tb_pf_iod_rx_lane_aligner;

  localparam logic [3:0] PATTERN    = 4'b1100;
  localparam int         SLIP_WAIT  = 4;
  localparam int         LOCK_COUNT = 16;
  localparam int         MAX_TAPS   = 4;
`ifdef PF_IOD_RX_DLY_SWEEP_EN
  localparam int SWEEP = 1;
`else
  localparam int SWEEP = 0;
`endif
  localparam int SLIP_PERIOD   = SLIP_WAIT + 2;
  localparam int LOCK_LATENCY  = SLIP_WAIT + LOCK_COUNT + 1;
  localparam int POSITION_SPAN = 4 * SLIP_PERIOD;
  localparam int POSITIONS     = SWEEP ? MAX_TAPS : 1;

  logic       FAB_CLK = 1'b0;
  logic       RX_SYNC_RST;
  logic       TRAIN_START;
  logic [3:0] rxData;
  logic       RX_BIT_SLIP;
  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_LOAD_0;
  logic       DELAY_LINE_OUT_OF_RANGE_0;
  logic [3:0] RX_WORD;
  logic       RX_VALID;
  logic       TRAIN_FAIL;
  logic [1:0] SLIP_CNT;

  int testsRun = 0;
  int testsFailed = 0;

  int cyc = 0;
  int slipQ[$];
  int moveQ[$];
  int loadCount, firstValid, firstFail, injectAt;
  int overlapCount = 0;
  int wordErrs = 0;
  int dirErrs = 0;
  int rot = 0;
  bit useConst = 1'b0;
  bit freezeIod = 1'b0;
  logic [3:0] constWord = 4'b0000;
  logic [3:0] injectWord = 4'b0000;

  pf_iod_rx_lane_aligner #(
    .TRAIN_PATTERN(PATTERN),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOCK_COUNT   (LOCK_COUNT),
    .MAX_TAPS     (MAX_TAPS)
  ) dut (
    .FAB_CLK                  (FAB_CLK),
    .RX_SYNC_RST              (RX_SYNC_RST),
    .TRAIN_START              (TRAIN_START),
    .RX_DATA_0                (rxData),
    .RX_BIT_SLIP              (RX_BIT_SLIP),
    .DELAY_LINE_MOVE_0        (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0   (DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_LOAD_0        (DELAY_LINE_LOAD_0),
    .DELAY_LINE_OUT_OF_RANGE_0(DELAY_LINE_OUT_OF_RANGE_0),
    .RX_WORD                  (RX_WORD),
    .RX_VALID                 (RX_VALID),
    .TRAIN_FAIL               (TRAIN_FAIL),
    .SLIP_CNT                 (SLIP_CNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Training word as seen after r left-rotations by the IOD.
  function automatic logic [3:0] rotWord(input int r);
    logic [7:0] d;
    d = {PATTERN, PATTERN} << r;
    return d[7:4];
  endfunction

  task automatic clearRec();
    slipQ.delete();
    moveQ.delete();
    loadCount  = 0;
    firstValid = -1;
    firstFail  = -1;
    injectAt   = -1;
  endtask

  // One clock: IOD reacts to last cycle's slip, data is driven, outputs are recorded.
  task automatic step();
    logic       slipNow;
    logic [3:0] expWord;
    slipNow = RX_BIT_SLIP;
    expWord = RX_SYNC_RST ? 4'b0000 : rxData;
    @(posedge FAB_CLK);
    #1;
    cyc++;
    if (RX_WORD !== expWord) wordErrs++;
    if (slipNow === 1'b1 && !freezeIod) rot = (rot + 1) % 4;
    if (useConst) rxData = constWord;
    else if (cyc == injectAt) rxData = injectWord;
    else rxData = rotWord(rot);
    if (RX_BIT_SLIP === 1'b1) slipQ.push_back(cyc);
    if (DELAY_LINE_MOVE_0 === 1'b1) moveQ.push_back(cyc);
    if (DELAY_LINE_LOAD_0 === 1'b1) loadCount++;
    if (RX_VALID === 1'b1 && firstValid < 0) firstValid = cyc;
    if (TRAIN_FAIL === 1'b1 && firstFail < 0) firstFail = cyc;
    if (int'(RX_BIT_SLIP) + int'(DELAY_LINE_MOVE_0) + int'(DELAY_LINE_LOAD_0) > 1) overlapCount++;
    if (DELAY_LINE_DIRECTION_0 !== DELAY_LINE_MOVE_0) dirErrs++;
  endtask

  task automatic startTraining(output int c);
    TRAIN_START = 1'b1;
    c = cyc;
    step();
    TRAIN_START = 1'b0;
  endtask

  task automatic observeUntil(input int budget);
    for (int n = 0; n < budget && firstValid < 0 && firstFail < 0; n++) step();
  endtask

  task automatic test_reset();
    RX_SYNC_RST = 1'b1;
    useConst = 1'b1;
    constWord = 4'b1010;
    rxData = constWord;
    clearRec();
    repeat (3) step();
    testsRun++;
    if (RX_VALID !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid: got %0b expected 0", RX_VALID); end
    testsRun++;
    if (TRAIN_FAIL !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_fail: got %0b expected 0", TRAIN_FAIL); end
    testsRun++;
    if (RX_BIT_SLIP !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_slip: got %0b expected 0", RX_BIT_SLIP); end
    testsRun++;
    if ({DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0} !== 3'b000) begin
      testsFailed++;
      $display("[TB] FAIL reset_delay: got %b expected 000", {DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0});
    end
    testsRun++;
    if (SLIP_CNT !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_slipcnt: got %0d expected 0", SLIP_CNT); end
    testsRun++;
    if (RX_WORD !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_word: got %b expected 0000", RX_WORD); end
    RX_SYNC_RST = 1'b0;
    clearRec();
    step();
    testsRun++;
    if (RX_WORD !== 4'b1010) begin testsFailed++; $display("[TB] FAIL idle_word: got %b expected 1010", RX_WORD); end
    repeat (20) step();
    testsRun++;
    if (slipQ.size() != 0 || firstValid >= 0) begin
      testsFailed++;
      $display("[TB] FAIL idle_hold: got slips=%0d valid_at=%0d expected 0 and -1", slipQ.size(), firstValid);
    end
  endtask

  task automatic test_aligned();
    int c;
    useConst = 1'b0;
    rot = 0;
    rxData = rotWord(rot);
    clearRec();
    startTraining(c);
    observeUntil(200);
    testsRun++;
    if (slipQ.size() != 0) begin testsFailed++; $display("[TB] FAIL aligned_slips: got %0d expected 0", slipQ.size()); end
    testsRun++;
    if (firstValid != c + LOCK_LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL aligned_lock_cycle: got %0d expected %0d", firstValid, c + LOCK_LATENCY);
    end
    testsRun++;
    if (SLIP_CNT !== 2'd0) begin testsFailed++; $display("[TB] FAIL aligned_slipcnt: got %0d expected 0", SLIP_CNT); end
    testsRun++;
    if (RX_WORD !== PATTERN) begin testsFailed++; $display("[TB] FAIL aligned_word: got %b expected %b", RX_WORD, PATTERN); end
    testsRun++;
    if (loadCount != SWEEP) begin testsFailed++; $display("[TB] FAIL aligned_load: got %0d expected %0d", loadCount, SWEEP); end
    useConst = 1'b1;
    constWord = 4'b0000;
    repeat (5) step();
    testsRun++;
    if (RX_VALID !== 1'b1) begin testsFailed++; $display("[TB] FAIL locked_hold: got %0b expected 1", RX_VALID); end
  endtask

  task automatic test_misaligned();
    int c, r, k, got;
    for (int it = 0; it < 6; it++) begin
      r = (it == 0) ? 2 : int'($urandom_range(0, 3));
      k = (4 - r) % 4;
      useConst = 1'b0;
      rot = r;
      rxData = rotWord(rot);
      clearRec();
      startTraining(c);
      observeUntil(300);
      testsRun++;
      if (slipQ.size() != k) begin testsFailed++; $display("[TB] FAIL misalign_slips r=%0d: got %0d expected %0d", r, slipQ.size(), k); end
      for (int j = 0; j < k; j++) begin
        got = (j < slipQ.size()) ? slipQ[j] : -1;
        testsRun++;
        if (got != c + SLIP_PERIOD * (j + 1)) begin
          testsFailed++;
          $display("[TB] FAIL misalign_slip_cycle r=%0d j=%0d: got %0d expected %0d", r, j, got, c + SLIP_PERIOD * (j + 1));
        end
      end
      testsRun++;
      if (firstValid != c + LOCK_LATENCY + SLIP_PERIOD * k) begin
        testsFailed++;
        $display("[TB] FAIL misalign_lock r=%0d: got %0d expected %0d", r, firstValid, c + LOCK_LATENCY + SLIP_PERIOD * k);
      end
      testsRun++;
      if (int'(SLIP_CNT) != k) begin testsFailed++; $display("[TB] FAIL misalign_slipcnt r=%0d: got %0d expected %0d", r, SLIP_CNT, k); end
    end
  endtask

  task automatic test_never_match();
    int c, got;
    useConst = 1'b1;
    constWord = 4'b0000;
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    clearRec();
    startTraining(c);
    observeUntil(POSITION_SPAN * MAX_TAPS + 50);
    testsRun++;
    if (firstFail != c + POSITION_SPAN * POSITIONS) begin
      testsFailed++;
      $display("[TB] FAIL nomatch_fail_cycle: got %0d expected %0d", firstFail, c + POSITION_SPAN * POSITIONS);
    end
    testsRun++;
    if (slipQ.size() != 3 * POSITIONS) begin testsFailed++; $display("[TB] FAIL nomatch_slips: got %0d expected %0d", slipQ.size(), 3 * POSITIONS); end
    for (int i = 0; i < 3 * POSITIONS; i++) begin
      got = (i < slipQ.size()) ? slipQ[i] : -1;
      testsRun++;
      if (got != c + POSITION_SPAN * (i / 3) + SLIP_PERIOD * (i % 3 + 1)) begin
        testsFailed++;
        $display("[TB] FAIL nomatch_slip_cycle i=%0d: got %0d expected %0d", i, got, c + POSITION_SPAN * (i / 3) + SLIP_PERIOD * (i % 3 + 1));
      end
    end
    testsRun++;
    if (moveQ.size() != POSITIONS - 1) begin testsFailed++; $display("[TB] FAIL nomatch_moves: got %0d expected %0d", moveQ.size(), POSITIONS - 1); end
    for (int i = 0; i < POSITIONS - 1; i++) begin
      got = (i < moveQ.size()) ? moveQ[i] : -1;
      testsRun++;
      if (got != c + POSITION_SPAN * (i + 1)) begin
        testsFailed++;
        $display("[TB] FAIL nomatch_move_cycle i=%0d: got %0d expected %0d", i, got, c + POSITION_SPAN * (i + 1));
      end
    end
    repeat (5) step();
    testsRun++;
    if (TRAIN_FAIL !== 1'b1 || firstValid >= 0) begin
      testsFailed++;
      $display("[TB] FAIL nomatch_hold: got fail=%0b valid_at=%0d expected 1 and -1", TRAIN_FAIL, firstValid);
    end
    testsRun++;
    if (SLIP_CNT !== 2'd3) begin testsFailed++; $display("[TB] FAIL nomatch_slipcnt: got %0d expected 3", SLIP_CNT); end
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
    clearRec();
    startTraining(c);
    testsRun++;
    if (TRAIN_FAIL !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_from_fail: got %0b expected 0", TRAIN_FAIL); end
    observeUntil(200);
    testsRun++;
    if (firstFail != c + POSITION_SPAN || moveQ.size() != 0 || slipQ.size() != 3) begin
      testsFailed++;
      $display("[TB] FAIL oor_fail: got fail_at=%0d moves=%0d slips=%0d expected %0d 0 3", firstFail, moveQ.size(), slipQ.size(), c + POSITION_SPAN);
    end
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
  endtask

  task automatic test_match_interrupt();
    int c;
    useConst = 1'b0;
    freezeIod = 1'b1;
    rot = 0;
    rxData = rotWord(rot);
    clearRec();
    startTraining(c);
    injectAt = c + SLIP_WAIT + 1 + 10;
    injectWord = rotWord(1 + int'($urandom_range(0, 2)));
    observeUntil(200);
    testsRun++;
    if (slipQ.size() != 1 || (slipQ.size() > 0 && slipQ[0] != injectAt + 1)) begin
      testsFailed++;
      $display("[TB] FAIL interrupt_slip: got count=%0d first=%0d expected 1 at %0d", slipQ.size(), (slipQ.size() > 0) ? slipQ[0] : -1, injectAt + 1);
    end
    testsRun++;
    if (firstValid != injectAt + 1 + LOCK_LATENCY) begin
      testsFailed++;
      $display("[TB] FAIL interrupt_lock: got %0d expected %0d", firstValid, injectAt + 1 + LOCK_LATENCY);
    end
    testsRun++;
    if (SLIP_CNT !== 2'd1) begin testsFailed++; $display("[TB] FAIL interrupt_slipcnt: got %0d expected 1", SLIP_CNT); end
    freezeIod = 1'b0;
    injectAt = -1;
  endtask

  task automatic test_restart();
    int c, c2;
    useConst = 1'b1;
    constWord = 4'b0000;
    clearRec();
    startTraining(c);
    repeat (SLIP_PERIOD - 1) step();
    testsRun++;
    if (RX_BIT_SLIP !== 1'b1) begin testsFailed++; $display("[TB] FAIL restart_slip_pre: got %0b expected 1", RX_BIT_SLIP); end
    clearRec();
    startTraining(c2);
    testsRun++;
    if (RX_BIT_SLIP !== 1'b0 || SLIP_CNT !== 2'd0) begin
      testsFailed++;
      $display("[TB] FAIL restart_in_slip: got slip=%0b cnt=%0d expected 0 0", RX_BIT_SLIP, SLIP_CNT);
    end
    testsRun++;
    if (loadCount != SWEEP) begin testsFailed++; $display("[TB] FAIL restart_slip_load: got %0d expected %0d", loadCount, SWEEP); end
    observeUntil(POSITION_SPAN * MAX_TAPS + 50);
    testsRun++;
    if (slipQ.size() == 0 || slipQ[0] != c2 + SLIP_PERIOD || firstFail != c2 + POSITION_SPAN * POSITIONS) begin
      testsFailed++;
      $display("[TB] FAIL restart_slip_retrain: got first_slip=%0d fail_at=%0d expected %0d %0d",
               (slipQ.size() > 0) ? slipQ[0] : -1, firstFail, c2 + SLIP_PERIOD, c2 + POSITION_SPAN * POSITIONS);
    end

    useConst = 1'b0;
    rot = 0;
    rxData = rotWord(rot);
    clearRec();
    startTraining(c);
    observeUntil(100);
    repeat (3) step();
    clearRec();
    startTraining(c2);
    testsRun++;
    if (RX_VALID !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_locked_valid: got %0b expected 0", RX_VALID); end
    testsRun++;
    if (loadCount != SWEEP) begin testsFailed++; $display("[TB] FAIL restart_locked_load: got %0d expected %0d", loadCount, SWEEP); end
    observeUntil(100);
    testsRun++;
    if (firstValid != c2 + LOCK_LATENCY) begin testsFailed++; $display("[TB] FAIL restart_locked_relock: got %0d expected %0d", firstValid, c2 + LOCK_LATENCY); end

    clearRec();
    startTraining(c);
    repeat (LOCK_LATENCY - 2) step();
    testsRun++;
    if (RX_VALID !== 1'b0) begin testsFailed++; $display("[TB] FAIL prelock_valid: got %0b expected 0", RX_VALID); end
    clearRec();
    startTraining(c2);
    testsRun++;
    if (RX_VALID !== 1'b0) begin testsFailed++; $display("[TB] FAIL restart_prelock_valid: got %0b expected 0", RX_VALID); end
    observeUntil(100);
    testsRun++;
    if (firstValid != c2 + LOCK_LATENCY) begin testsFailed++; $display("[TB] FAIL restart_prelock_relock: got %0d expected %0d", firstValid, c2 + LOCK_LATENCY); end

    useConst = 1'b1;
    constWord = 4'b0000;
    clearRec();
    startTraining(c);
    repeat (SLIP_PERIOD + 1) step();
    testsRun++;
    if (SLIP_CNT !== 2'd1) begin testsFailed++; $display("[TB] FAIL midwait_slipcnt: got %0d expected 1", SLIP_CNT); end
    RX_SYNC_RST = 1'b1;
    constWord = 4'b1010;
    rxData = constWord;
    step();
    testsRun++;
    if ({RX_BIT_SLIP, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, RX_VALID, TRAIN_FAIL, SLIP_CNT, RX_WORD} !== 12'd0) begin
      testsFailed++;
      $display("[TB] FAIL midwait_reset: got slip=%0b mv=%0b dir=%0b ld=%0b v=%0b f=%0b cnt=%0d word=%b expected all 0",
               RX_BIT_SLIP, DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0, RX_VALID, TRAIN_FAIL, SLIP_CNT, RX_WORD);
    end
    RX_SYNC_RST = 1'b0;
    clearRec();
    repeat (30) step();
    testsRun++;
    if (slipQ.size() != 0 || firstFail >= 0) begin
      testsFailed++;
      $display("[TB] FAIL reset_idle_hold: got slips=%0d fail_at=%0d expected 0 and -1", slipQ.size(), firstFail);
    end
  endtask

  task automatic test_pulse_integrity();
    testsRun++;
    if (overlapCount != 0) begin testsFailed++; $display("[TB] FAIL pulse_overlap: got %0d expected 0", overlapCount); end
    testsRun++;
    if (wordErrs != 0) begin testsFailed++; $display("[TB] FAIL rx_word_delay: got %0d errors expected 0", wordErrs); end
    testsRun++;
    if (dirErrs != 0) begin testsFailed++; $display("[TB] FAIL direction: got %0d errors expected 0", dirErrs); end
  endtask

  initial begin
    RX_SYNC_RST = 1'b1;
    TRAIN_START = 1'b0;
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    rxData = 4'b0000;
    clearRec();
    test_reset();
    test_aligned();
    test_misaligned();
    test_never_match();
    test_match_interrupt();
    test_restart();
    test_pulse_integrity();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
